imem_load_fetch_ctrl: RTL and testbench
=======================================

# imem_load_fetch_ctrl

Controller that owns the port of the single-port, word-wide, synchronous instruction memory and shares it between two users. After reset it runs a program loader that assembles a big-endian byte stream into 32-bit words and writes them to consecutive word addresses. It then switches to serving the pipeline's fetch stage, and holds the CPU stalled until loading completes. It sits between the test/boot byte source, the IF stage, and the instruction memory array.

## Interface
- DEPTH_WORDS, 128: memory depth in 32-bit words; power of two, ≥2
- AW, $clog2(DEPTH_WORDS): word-address width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- ld_data  in  8  loader byte
- ld_valid  in  1  ld_data valid
- ld_last  in  1  qualifies the final byte of the stream
- ld_ready  out  1  loader may present a byte
- fetch_en  in  1  IF stage requests an instruction this cycle
- pc  in  32  byte address of the requested instruction
- instr  out  32  fetched instruction; 0 (NOP) on error
- fetch_valid  out  1  instr valid
- fetch_err  out  1  the request was misaligned or beyond the program
- mem_addr  out  AW  memory word address
- mem_wdata  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  32  memory read data, 1-cycle latency after mem_addr
- cpu_stall  out  1  pipeline must hold its PC
- load_err  out  1  sticky load fault
- prog_words  out  AW+1  number of words written

## Operation
- States: LOAD (the state after reset), RUN, FAULT.
- LOAD:
  - ld_ready=1. A byte is accepted on ld_valid&&ld_ready.
  - Bytes fill the word MSB-first: byte0→[31:24], byte3→[7:0].
  - On the 4th accepted byte, or on an accepted byte with ld_last: the next cycle drives mem_we=1, mem_addr=prog_words[AW-1:0], mem_wdata=assembled word. prog_words increments on that cycle.
  - A partial final word is zero-padded in its unfilled low bytes.
  - Bytes may continue to be accepted during the write cycle.
- LOAD→RUN: in the cycle after the final write. ld_ready drops at the ld_last handshake.
- Overflow: a byte accepted while prog_words==DEPTH_WORDS and the byte counter is 0 goes to FAULT. That byte is not written.
- RUN:
  - mem_we=0 and mem_addr=pc[AW+1:2] on every fetch_en.
  - Error conditions: pc[1:0]≠0, or pc[31:2]≥prog_words. Either forces instr=0 and fetch_err=1.
  - Bytes offered on the loader port are ignored (ld_ready=0).
- FAULT: load_err=1, cpu_stall=1, ld_ready=0, mem_we=0. The block stays in FAULT until reset.
- Reset mid-operation:
  - State returns to LOAD. prog_words and the byte counter are cleared.
  - Memory contents are left unchanged.
  - A write pending at reset is dropped.

## Timing
- Reset values: ld_ready=1, cpu_stall=1. All other outputs 0: instr, fetch_valid, fetch_err, mem_addr, mem_wdata, mem_we, load_err, prog_words.
- Load write latency: mem_we rises 1 cycle after the completing byte handshake.
- cpu_stall falls 1 cycle after the final mem_we cycle, i.e. on entry to RUN.
- Fetch latency is 1 cycle. fetch_en/pc are sampled at edge N; instr, fetch_valid=1 and fetch_err are registered and visible after edge N+1.
- fetch_valid is low in any cycle with no request in the previous cycle. instr holds its last value while fetch_valid is low.
- fetch_en while cpu_stall=1 is ignored: no fetch_valid.
- Sustained throughput: 1 byte/cycle on load, 1 instruction/cycle on fetch.

## Configuration
- IMEM_LOAD_CSUM_EN defined:
  - The byte carrying ld_last is a checksum, not data. It must equal the XOR of all preceding data bytes.
  - The final partial word is written when the checksum byte is accepted.
  - Match: the block enters RUN as normal.
  - Mismatch: FAULT with load_err=1. Words already written remain in memory.
- IMEM_LOAD_CSUM_EN undefined: the ld_last byte is data, and load_err is asserted only on overflow.

## Test plan
- Basic load, macro off: bytes 20 08 00 05 (ld_last on the 4th byte) → one cycle later mem_we=1, addr 0, wdata 0x20080005. prog_words=1, cpu_stall=0 on the following cycle. fetch_en with pc=0 → next cycle instr=0x20080005, fetch_valid=1, fetch_err=0.
- Partial word: AA BB CC DD 11 22 (last) → writes 0xAABBCCDD at addr 0 and 0x11220000 at addr 1. prog_words=2.
- Fetch errors after that load:
  - pc=8 → instr=0, fetch_err=1.
  - pc=2 → instr=0, fetch_err=1.
  - pc=4 → instr=0x11220000, fetch_err=0.
- Overflow with DEPTH_WORDS=2: 9 bytes are offered, ld_last never asserted → two writes occur. The 9th byte sets load_err=1, cpu_stall stays 1, ld_ready=0, and there is no third mem_we.
- Reset mid-load: assert reset after 2 bytes → all outputs at reset values. A fresh 4-byte load then writes to addr 0.
- Macro on: data 01 02 03 04 with checksum 04 → RUN, word 0x01020304. Repeat with checksum 05 → load_err=1 and FAULT held until reset.

Source files
------------

// File: rtl/imem_load_fetch_ctrl_if.sv
// imem_load_fetch_ctrl_if: loader byte stream, IF-stage fetch and instruction-memory port signals.
// slave is the controller side; master is the environment (loader, IF stage, memory array).
interface imem_load_fetch_ctrl_if #(parameter int AW = 7);
   logic [7:0]  ld_data;
   logic        ld_valid;
   logic        ld_last;
   logic        ld_ready;
   logic        fetch_en;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        fetch_valid;
   logic        fetch_err;
   logic [AW-1:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic        cpu_stall;
   logic        load_err;
   logic [AW:0] prog_words;
   modport slave (
      input  ld_data, ld_valid, ld_last, fetch_en, pc, mem_rdata,
      output ld_ready, instr, fetch_valid, fetch_err, mem_addr, mem_wdata, mem_we,
             cpu_stall, load_err, prog_words
   );
   modport master (
      output ld_data, ld_valid, ld_last, fetch_en, pc, mem_rdata,
      input  ld_ready, instr, fetch_valid, fetch_err, mem_addr, mem_wdata, mem_we,
             cpu_stall, load_err, prog_words
   );
endinterface

// File: rtl/imem_load_fetch_ctrl.sv
// imem_load_fetch_ctrl: shares a single-port instruction memory between a byte-stream program loader and IF fetch.
// Define IMEM_LOAD_CSUM_EN to treat the ld_last byte as an XOR checksum of all preceding data bytes.
module imem_load_fetch_ctrl #(
   parameter int DEPTH_WORDS = 128,
   parameter int AW = $clog2(DEPTH_WORDS)
) (
   input logic clk,
   input logic reset,
   imem_load_fetch_ctrl_if.slave bus
);
   typedef enum logic [1:0] {LOAD, RUN, FAULT} state_t;
   state_t state, state_nx;
   logic [1:0] cnt;
   logic [7:0] csum;
   logic [31:0] wbuf, wdat, nword;
   logic [AW:0] pw;
   logic wr_pend, done, bad, req_v, req_err;
   logic acc, csum_byte, bad_now, full, ovf, word_done;
   always_comb begin
      acc = state == LOAD && !done && bus.ld_valid;
`ifdef IMEM_LOAD_CSUM_EN
      csum_byte = bus.ld_last;
`else
      csum_byte = 1'b0;
`endif
      bad_now = csum_byte && (csum ^ bus.ld_data) != 8'd0;
      // a write already in flight counts toward capacity
      full = pw + (AW+1)'(wr_pend) == (AW+1)'(DEPTH_WORDS);
      ovf = acc && !csum_byte && cnt == 2'd0 && full;
      word_done = acc && !ovf && (csum_byte ? cnt != 2'd0 : (cnt == 2'd3 || bus.ld_last));
      nword = cnt == 2'd0 ? 32'd0 : wbuf;
      nword[{~cnt, 3'b000} +: 8] = bus.ld_data;
      state_nx = state != LOAD ? state :
                 ovf ? FAULT :
                 done ? (bad ? FAULT : RUN) :
                 (acc && csum_byte && cnt == 2'd0) ? (bad_now ? FAULT : RUN) : LOAD;
   end
   assign bus.ld_ready = state == LOAD && !done;
   assign bus.cpu_stall = state != RUN;
   assign bus.load_err = state == FAULT;
   assign bus.mem_we = wr_pend;
   assign bus.mem_addr = wr_pend ? pw[AW-1:0] : (state == RUN && bus.fetch_en) ? bus.pc[AW+1:2] : '0;
   assign bus.mem_wdata = wr_pend ? wdat : 32'd0;
   assign bus.prog_words = pw;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= LOAD;
         cnt <= 2'd0;
         csum <= 8'd0;
         wbuf <= 32'd0;
         wdat <= 32'd0;
         pw <= '0;
         wr_pend <= 1'b0;
         done <= 1'b0;
         bad <= 1'b0;
         req_v <= 1'b0;
         req_err <= 1'b0;
         bus.instr <= 32'd0;
         bus.fetch_valid <= 1'b0;
         bus.fetch_err <= 1'b0;
      end else begin
         state <= state_nx;
         wr_pend <= word_done;
         if (wr_pend) pw <= pw + (AW+1)'(1);
         if (word_done) wdat <= csum_byte ? wbuf : nword;
         if (acc && !ovf) begin
            done <= done || bus.ld_last;
            bad <= bad_now;
            if (!csum_byte) begin
               cnt <= cnt + 2'd1;
               wbuf <= nword;
               csum <= csum ^ bus.ld_data;
            end
         end
         req_v <= state == RUN && bus.fetch_en;
         req_err <= bus.pc[1:0] != 2'd0 || bus.pc[31:2] >= 30'(pw);
         bus.fetch_valid <= req_v;
         bus.fetch_err <= req_v && req_err;
         if (req_v) bus.instr <= req_err ? 32'd0 : bus.mem_rdata;
      end
   end
endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// tb_imem_load_fetch_ctrl: scoreboarded bench for a 128-word instance (load/fetch) and a 2-word instance (overflow).
module tb_imem_load_fetch_ctrl;
   typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
   typedef struct packed { logic [31:0] instr; logic err; } rd_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } vec_t;
   logic clk = 1'b0, rst = 1'b1;
   int n_vec = 0, n_mis = 0;
   wr_t wq0[$], wq1[$];
   rd_t fq0[$];
   logic [31:0] mem0 [128];
   logic [31:0] mem1 [2];
   logic [7:0] pb [6];
   vec_t vt [8];
   imem_load_fetch_ctrl_if #(.AW(7)) b0();
   imem_load_fetch_ctrl_if #(.AW(1)) b1();
   imem_load_fetch_ctrl u0 (.clk(clk), .reset(rst), .bus(b0));
   imem_load_fetch_ctrl #(.DEPTH_WORDS(2)) u1 (.clk(clk), .reset(rst), .bus(b1));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (b0.mem_we) mem0[b0.mem_addr] <= b0.mem_wdata;
      b0.mem_rdata <= mem0[b0.mem_addr];
      if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
      b1.mem_rdata <= mem1[b1.mem_addr];
   end
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   task automatic chk1(input string nm, input logic act, input logic exp);
      chk(nm, 128'(act), 128'(exp));
   endtask
   task automatic miss(input string nm, input logic [127:0] act);
      n_vec++;
      n_mis++;
      $display("FAIL %s: got %0h, expected no output", nm, act);
   endtask
   always @(negedge clk) begin
      if (b0.mem_we) begin
         if (wq0.size() == 0) miss("u0 stray write", 128'({b0.mem_addr, b0.mem_wdata}));
         else chk("u0 write", 128'({32'(b0.mem_addr), b0.mem_wdata}), 128'(wq0.pop_front()));
      end
      if (b1.mem_we) begin
         if (wq1.size() == 0) miss("u1 stray write", 128'({b1.mem_addr, b1.mem_wdata}));
         else chk("u1 write", 128'({32'(b1.mem_addr), b1.mem_wdata}), 128'(wq1.pop_front()));
      end
      if (b0.fetch_valid) begin
         if (fq0.size() == 0) miss("u0 stray fetch", 128'({b0.instr, b0.fetch_err}));
         else chk("u0 fetch", 128'({b0.instr, b0.fetch_err}), 128'(fq0.pop_front()));
      end
   end
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send0(input logic [7:0] d, input logic l);
      b0.ld_valid = 1'b1;
      b0.ld_data = d;
      b0.ld_last = l;
      cyc(1);
      b0.ld_valid = 1'b0;
      b0.ld_last = 1'b0;
   endtask
   task automatic fetch0(input logic [31:0] a, input logic [31:0] ins, input logic e);
      fq0.push_back(rd_t'{ins, e});
      b0.fetch_en = 1'b1;
      b0.pc = a;
      cyc(1);
      b0.fetch_en = 1'b0;
   endtask
   task automatic chk_rst0(input string nm);
      chk(nm, 128'({b0.ld_ready, b0.cpu_stall, b0.instr, b0.fetch_valid, b0.fetch_err, b0.mem_addr,
                    b0.mem_wdata, b0.mem_we, b0.load_err, b0.prog_words}), 128'({2'b11, 83'd0}));
   endtask
   task automatic do_reset(input string nm);
      rst = 1'b1;
      #2;
      chk_rst0(nm);
      cyc(2);
      rst = 1'b0;
   endtask
   task automatic wait_run0(input string nm);
      for (int i = 0; i < 10 && b0.cpu_stall; i++) cyc(1);
      chk1(nm, b0.cpu_stall, 1'b0);
   endtask
   initial begin
      b0.ld_valid = 1'b0; b0.ld_data = 8'd0; b0.ld_last = 1'b0; b0.fetch_en = 1'b0; b0.pc = 32'd0;
      b1.ld_valid = 1'b0; b1.ld_data = 8'd0; b1.ld_last = 1'b0; b1.fetch_en = 1'b0; b1.pc = 32'd0;
      cyc(2);
      chk_rst0("u0 reset values");
      chk("u1 reset values", 128'({b1.ld_ready, b1.cpu_stall, b1.load_err, b1.mem_we, b1.prog_words}),
          128'(6'b110000));
      rst = 1'b0;
`ifndef IMEM_LOAD_CSUM_EN
      wq0.push_back(wr_t'{32'd0, 32'h20080005});
      send0(8'h20, 1'b0); send0(8'h08, 1'b0); send0(8'h00, 1'b0); send0(8'h05, 1'b1);
      chk1("ld_ready drops after last byte", b0.ld_ready, 1'b0);
      chk1("mem_we one cycle after last byte", b0.mem_we, 1'b1);
      chk1("stall held during final write", b0.cpu_stall, 1'b1);
      cyc(1);
      chk1("stall released on RUN", b0.cpu_stall, 1'b0);
      chk("prog_words after basic load", 128'(b0.prog_words), 128'(1));
      fetch0(32'd0, 32'h20080005, 1'b0);
      cyc(2);
      do_reset("u0 reset before partial load");
      b0.fetch_en = 1'b1; b0.pc = 32'd0;
      cyc(2);
      b0.fetch_en = 1'b0;
      chk1("fetch ignored while stalled", b0.fetch_valid, 1'b0);
      wq0.push_back(wr_t'{32'd0, 32'hAABBCCDD});
      wq0.push_back(wr_t'{32'd1, 32'h11220000});
      pb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      for (int i = 0; i < 6; i++) send0(pb[i], i == 5);
      wait_run0("RUN after partial load");
      chk("prog_words after partial load", 128'(b0.prog_words), 128'(2));
      vt = '{'{32'h0, 32'hAABBCCDD, 1'b0}, '{32'h8, 32'h0, 1'b1}, '{32'h2, 32'h0, 1'b1},
             '{32'hC, 32'h0, 1'b1}, '{32'h1, 32'h0, 1'b1}, '{32'h200, 32'h0, 1'b1},
             '{32'hFFFF_FFFC, 32'h0, 1'b1}, '{32'h4, 32'h11220000, 1'b0}};
      for (int i = 0; i < 8; i++) fetch0(vt[i].pc, vt[i].instr, vt[i].err);
      cyc(2);
      chk1("fetch_valid low when idle", b0.fetch_valid, 1'b0);
      chk("instr holds when idle", 128'(b0.instr), 128'(32'h11220000));
      do_reset("u0 reset before mid-load reset");
      send0(8'h55, 1'b0); send0(8'h66, 1'b0);
      do_reset("u0 reset mid-load");
      wq0.push_back(wr_t'{32'd0, 32'hDEADBEEF});
      send0(8'hDE, 1'b0); send0(8'hAD, 1'b0); send0(8'hBE, 1'b0); send0(8'hEF, 1'b1);
      wait_run0("RUN after reload");
      chk("prog_words after reload", 128'(b0.prog_words), 128'(1));
      fetch0(32'd0, 32'hDEADBEEF, 1'b0);
      fetch0(32'd4, 32'h0, 1'b1);
      cyc(2);
      do_reset("u0 reset before pending-write drop");
      send0(8'h01, 1'b0); send0(8'h02, 1'b0); send0(8'h03, 1'b0); send0(8'h04, 1'b0);
      rst = 1'b1;
      #2;
      chk1("pending write dropped by reset", b0.mem_we, 1'b0);
      cyc(1);
      rst = 1'b0;
`else
      wq0.push_back(wr_t'{32'd0, 32'h01020304});
      send0(8'h01, 1'b0); send0(8'h02, 1'b0); send0(8'h03, 1'b0); send0(8'h04, 1'b0);
      send0(8'h04, 1'b1);
      chk1("checksum match enters RUN", b0.cpu_stall, 1'b0);
      chk1("no load_err on match", b0.load_err, 1'b0);
      chk("prog_words after checksum load", 128'(b0.prog_words), 128'(1));
      fetch0(32'd0, 32'h01020304, 1'b0);
      cyc(2);
      do_reset("u0 reset before partial checksum load");
      wq0.push_back(wr_t'{32'd0, 32'h01020300});
      send0(8'h01, 1'b0); send0(8'h02, 1'b0); send0(8'h03, 1'b0); send0(8'h00, 1'b1);
      wait_run0("checksum partial word enters RUN");
      chk("prog_words after partial checksum load", 128'(b0.prog_words), 128'(1));
      fetch0(32'd0, 32'h01020300, 1'b0);
      cyc(2);
      do_reset("u0 reset before checksum mismatch");
      wq0.push_back(wr_t'{32'd0, 32'h01020304});
      send0(8'h01, 1'b0); send0(8'h02, 1'b0); send0(8'h03, 1'b0); send0(8'h04, 1'b0);
      send0(8'h05, 1'b1);
      chk1("checksum mismatch sets load_err", b0.load_err, 1'b1);
      chk1("stall held in FAULT", b0.cpu_stall, 1'b1);
      chk1("ld_ready low in FAULT", b0.ld_ready, 1'b0);
      cyc(3);
      chk1("FAULT held until reset", b0.load_err, 1'b1);
      do_reset("reset clears FAULT");
`endif
      wq1.push_back(wr_t'{32'd0, 32'h10111213});
      wq1.push_back(wr_t'{32'd1, 32'h14151617});
      b1.ld_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         b1.ld_data = 8'(8'h10 + i);
         cyc(1);
      end
      chk1("overflow sets load_err", b1.load_err, 1'b1);
      chk1("overflow keeps stall", b1.cpu_stall, 1'b1);
      chk1("overflow drops ld_ready", b1.ld_ready, 1'b0);
      chk("prog_words at overflow", 128'(b1.prog_words), 128'(2));
      b1.ld_data = 8'h99;
      cyc(4);
      b1.ld_valid = 1'b0;
      chk1("FAULT held after overflow", b1.load_err, 1'b1);
      for (int i = 0; i < 20 && (wq0.size() != 0 || wq1.size() != 0 || fq0.size() != 0); i++) cyc(1);
      chk("write queues drained", 128'(wq0.size() + wq1.size()), 128'(0));
      chk("fetch queue drained", 128'(fq0.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
